rx_frame_checker: RTL and testbench

Receive-side counterpart of the USRT transmit framer. It samples the serial line one bit per i_Pclk cycle and detects the start bit. It shifts in the data bits LSB-first, checks the parity slot against the selected parity mode, checks the stop bit, and presents the recovered byte with error flags through a valid/ready holding register. It sits between the synchronous serial input pin and the receive-side consumer (FIFO or register interface).

---
 rtl/usrt_pkg.sv | 21 ++
 rtl/rx_frame_checker_if.sv | 25 ++
 rtl/rx_frame_checker_parity_calc.sv | 28 ++
 rtl/rx_frame_checker.sv | 110 +++++++++++
 tb/tb_rx_frame_checker.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/usrt_pkg.sv
// Shared USRT definitions: parity mode encodings, frame geometry and the
// receive-side state encoding.
package usrt_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    localparam int DATA_W_DFLT = 8;
    // start + data + parity slot + stop
    localparam int FRAME_LEN   = DATA_W_DFLT + 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_IDLE
    } rx_state_t;

endpackage

// File: rtl/rx_frame_checker_if.sv
// Serial line, parity mode and received-byte handshake for the USRT receiver.
// master = the frame checker, slave = the line driver / byte consumer.
interface rx_frame_checker_if #(parameter int DATA_W = 8);

    logic              i_Rx;
    logic [1:0]        i_Parity;
    logic [DATA_W-1:0] o_Data;
    logic              o_Valid;
    logic              i_Ready;
    logic              o_ParityErr;
    logic              o_FrameErr;
    logic              o_Overrun;
    logic              o_Busy;

    modport master (
        input  i_Rx, i_Parity, i_Ready,
        output o_Data, o_Valid, o_ParityErr, o_FrameErr, o_Overrun, o_Busy
    );

    modport slave (
        output i_Rx, i_Parity, i_Ready,
        input  o_Data, o_Valid, o_ParityErr, o_FrameErr, o_Overrun, o_Busy
    );

endinterface

// File: rtl/rx_frame_checker_parity_calc.sv
// Expected parity bit for a data word under a given parity mode; the transmit
// framer uses the same block so both ends agree on the parity definition.
module parity_calc
    import usrt_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] data,
    input  logic [1:0]        mode,
    output logic              par_exp,
    output logic              par_en
);

    always_comb begin
        par_exp = ^data;
        par_en  = 1'b1;
        case (mode)
            PAR_EVEN: par_exp = ^data;
            PAR_ODD:  par_exp = ~(^data);
            // none and the reserved 11 code: slot present but not checked
            default: begin
                par_exp = 1'b0;
                par_en  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/rx_frame_checker.sv
// USRT receive framer: one bit per i_Pclk, start/data/parity/stop checking,
// and a single valid/ready holding register with sticky overrun.
module rx_frame_checker
    import usrt_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                i_Pclk,
    input  logic                i_Rst_n,
    rx_frame_checker_if.master  bus
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    rx_state_t         state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] shreg;
    logic [1:0]        mode;
    logic              par_bit;
    logic              par_exp;
    logic              par_en;

    logic [DATA_W-1:0] data_q;
    logic              valid_q;
    logic              perr_q;
    logic              ferr_q;
    logic              ovr_q;
    logic              busy_q;
    logic              accept;

    parity_calc #(.DATA_W(DATA_W)) u_parity_calc (
        .data    (shreg),
        .mode    (mode),
        .par_exp (par_exp),
        .par_en  (par_en)
    );

    assign accept = valid_q & bus.i_Ready;

    always_ff @(posedge i_Pclk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            shreg   <= '0;
            mode    <= '0;
            par_bit <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            if (accept) begin
                valid_q <= 1'b0;
                ovr_q   <= 1'b0;
            end
            case (state)
                ST_IDLE: if (!bus.i_Rx) begin
                    state  <= ST_DATA;
                    cnt    <= '0;
                    mode   <= bus.i_Parity;
                    busy_q <= 1'b1;
                end
                ST_DATA: begin
                    shreg[cnt] <= bus.i_Rx;
                    if (cnt == CNT_W'(DATA_W - 1)) state <= ST_PARITY;
                    else                           cnt   <= cnt + 1'b1;
                end
                ST_PARITY: begin
                    par_bit <= bus.i_Rx;
                    state   <= ST_STOP;
                end
                ST_STOP: begin
                    // an accept this cycle frees the holder for the new frame
                    if (!valid_q || bus.i_Ready) begin
                        data_q  <= shreg;
                        perr_q  <= par_en & (par_bit != par_exp);
                        ferr_q  <= ~bus.i_Rx;
                        valid_q <= 1'b1;
                    end else begin
                        ovr_q   <= 1'b1;
                    end
                    if (bus.i_Rx) begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        state  <= ST_WAIT_IDLE;
                    end
                end
                ST_WAIT_IDLE: if (bus.i_Rx) begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_Data      = data_q;
    assign bus.o_Valid     = valid_q;
    assign bus.o_ParityErr = perr_q;
    assign bus.o_FrameErr  = ferr_q;
    assign bus.o_Overrun   = ovr_q;
    assign bus.o_Busy      = busy_q;

endmodule

// File: tb/tb_rx_frame_checker.sv
// Scoreboard bench for rx_frame_checker: frames are queued when driven and
// matched against each newly loaded holder value, including arrival cycle.
module tb_rx_frame_checker;
    import usrt_pkg::*;

    localparam int DW = 8;

    logic i_Pclk  = 1'b0;
    logic i_Rst_n = 1'b0;

    rx_frame_checker_if #(.DATA_W(DW)) bus ();

    rx_frame_checker #(.DATA_W(DW)) dut (
        .i_Pclk  (i_Pclk),
        .i_Rst_n (i_Rst_n),
        .bus     (bus)
    );

    always #5 i_Pclk = ~i_Pclk;

    typedef struct {
        logic [DW-1:0] data;
        logic          perr;
        logic          ferr;
        int            cyc;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    logic prev_v = 1'b0;
    logic prev_r = 1'b0;

    always @(posedge i_Pclk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic exp_perr(input logic [DW-1:0] d, input logic [1:0] m, input logic p);
        case (m)
            PAR_EVEN: return p != (^d);
            PAR_ODD:  return p != ~(^d);
            default:  return 1'b0;
        endcase
    endfunction

    // a new frame is in the holder when valid rises or follows an accept
    always @(negedge i_Pclk) begin
        if (!i_Rst_n) begin
            prev_v <= 1'b0;
            prev_r <= 1'b0;
        end else begin
            if (bus.o_Valid && (!prev_v || prev_r)) begin
                if (sb.size() == 0) begin
                    chk("spurious_frame", {24'h0, bus.o_Data}, 32'h1_0000);
                end else begin
                    m_e = sb.pop_front();
                    chk("data",    bus.o_Data,      m_e.data);
                    chk("perr",    bus.o_ParityErr, m_e.perr);
                    chk("ferr",    bus.o_FrameErr,  m_e.ferr);
                    chk("arrival", cyc,             m_e.cyc);
                end
            end
            prev_v <= bus.o_Valid;
            prev_r <= bus.i_Ready;
        end
    end

    task automatic bit_out(input logic b);
        @(posedge i_Pclk); #1;
        bus.i_Rx = b;
    endtask

    task automatic idle(input int n);
        repeat (n) bit_out(1'b1);
    endtask

    task automatic send(input logic [DW-1:0] d, input logic p, input logic s,
                        input logic [1:0] m, input bit deliver);
        exp_t e;
        @(posedge i_Pclk); #1;
        bus.i_Rx     = 1'b0;
        bus.i_Parity = m;
        e.data = d;
        e.perr = exp_perr(d, m, p);
        e.ferr = ~s;
        e.cyc  = cyc + FRAME_LEN;
        if (deliver) sb.push_back(e);
        for (int i = 0; i < DW; i++) begin
            bit_out(d[i]);
            bus.i_Parity = ~m;   // must not affect the frame in flight
        end
        bit_out(p);
        bit_out(s);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_data"},  {24'h0, bus.o_Data}, 32'h0);
        chk({tag, "_valid"}, bus.o_Valid,         32'h0);
        chk({tag, "_perr"},  bus.o_ParityErr,     32'h0);
        chk({tag, "_ferr"},  bus.o_FrameErr,      32'h0);
        chk({tag, "_ovr"},   bus.o_Overrun,       32'h0);
        chk({tag, "_busy"},  bus.o_Busy,          32'h0);
    endtask

    initial begin
        bus.i_Rx     = 1'b1;
        bus.i_Parity = PAR_EVEN;
        bus.i_Ready  = 1'b1;
        repeat (3) @(posedge i_Pclk);
        #1;
        chk_all_zero("reset");
        i_Rst_n = 1'b1;
        idle(2);

        // even mode, clean frame
        send(8'hA5, 1'b0, 1'b1, PAR_EVEN, 1);
        idle(3);

        // wrong odd parity, then the same slot ignored in none mode
        send(8'h07, 1'b1, 1'b1, PAR_ODD, 1);
        send(8'h07, 1'b1, 1'b1, PAR_NONE, 1);
        idle(3);

        // framing error followed by a held-low line
        send(8'h3C, 1'b0, 1'b0, PAR_EVEN, 1);
        repeat (5) bit_out(1'b0);
        chk("busy_break", bus.o_Busy, 32'h1);
        bit_out(1'b1);
        @(posedge i_Pclk); #1;
        chk("busy_released", bus.o_Busy, 32'h0);
        idle(2);

        // overrun: second frame dropped while the holder is full
        bus.i_Ready = 1'b0;
        send(8'h11, 1'b0, 1'b1, PAR_EVEN, 1);
        send(8'h22, 1'b0, 1'b1, PAR_EVEN, 0);
        idle(2);
        chk("ovr_data",  {24'h0, bus.o_Data}, 32'h11);
        chk("ovr_valid", bus.o_Valid,         32'h1);
        chk("ovr_flag",  bus.o_Overrun,       32'h1);
        bus.i_Ready = 1'b1;
        @(posedge i_Pclk); #1;
        chk("ovr_acc_valid", bus.o_Valid,   32'h0);
        chk("ovr_acc_flag",  bus.o_Overrun, 32'h0);

        // back-to-back with the consumer always ready
        send(8'h01, 1'b1, 1'b1, PAR_EVEN, 1);
        send(8'h80, 1'b1, 1'b1, PAR_EVEN, 1);
        send(8'hFF, 1'b0, 1'b1, PAR_EVEN, 1);
        idle(3);
        chk("b2b_ovr", bus.o_Overrun, 32'h0);

        // reset in the middle of a frame, then a clean frame
        @(posedge i_Pclk); #1;
        bus.i_Rx     = 1'b0;
        bus.i_Parity = PAR_EVEN;
        for (int i = 0; i < 4; i++) bit_out(logic'(8'h5A >> i));
        @(posedge i_Pclk); #1;
        i_Rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        bus.i_Rx = 1'b1;
        @(posedge i_Pclk); #1;
        i_Rst_n = 1'b1;
        idle(2);
        send(8'hC3, 1'b0, 1'b1, PAR_EVEN, 1);
        idle(3);

        for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge i_Pclk);
        chk("drain", sb.size(), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
